hazard_control_unit: RTL and testbench

- Pipeline sequencing controller for the 5-stage RV32I core (IF/ID/EX/MEM/WB).
- Decides per cycle which stage registers hold, which are flushed or bubbled, and which operand sources feed the ALU in EX.
- Handles load-use stalls, taken-branch/jump redirects with a programmable flush window, and data-memory wait states with a timeout.
- Sits beside the decode stage; consumes register indices and decoded control bits, drives stage-register enables/clears and forwarding muxes.

---
 rtl/hazard_control_unit.sv | 106 ++++++++++
 tb/tb_hazard_control_unit.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/hazard_control_unit.sv
// hazard_control_unit: RV32I pipeline stall/flush/forward sequencing; optional perf counters via HAZARD_PERF_COUNTERS_EN
module hazard_control_unit #(
  parameter int BRANCH_PENALTY = 2,
  parameter int MAX_MEM_WAIT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_uses_rs1,
  input  logic       id_uses_rs2,
  input  logic [4:0] ex_rs1,
  input  logic [4:0] ex_rs2,
  input  logic [4:0] ex_rd,
  input  logic       ex_mem_read,
  input  logic       ex_redirect,
  input  logic [4:0] mem_rd,
  input  logic       mem_reg_write,
  input  logic       mem_req,
  input  logic       mem_ready,
  input  logic [4:0] wb_rd,
  input  logic       wb_reg_write,
  output logic       stall_if,
  output logic       stall_id,
  output logic       stall_ex,
  output logic       stall_mem,
  output logic       flush_if_id,
  output logic       bubble_id_ex,
  output logic [1:0] forward_a,
  output logic [1:0] forward_b,
`ifdef HAZARD_PERF_COUNTERS_EN
  output logic [31:0] perf_load_use_stalls,
  output logic [31:0] perf_flush_cycles,
  output logic [31:0] perf_mem_wait_cycles,
`endif
  output logic       mem_timeout
);
  typedef enum logic [1:0] {RUN, MEM_WAIT, FLUSH} state_t;
  localparam logic [2:0] PEN = 3'(BRANCH_PENALTY - 1);
  localparam logic [7:0] WMAX = 8'(MAX_MEM_WAIT);
  state_t state;
  logic [2:0] flush_cnt;
  logic [7:0] wait_cnt;
  logic frozen, redirect, in_flush, wrong_path, hazard_ld, load_use;
  // frozen pipeline overrides everything; a pending flush window marks the ID instruction as wrong-path
  always_comb begin
    frozen = !reset && mem_req && !mem_ready;
    redirect = !reset && !frozen && ex_redirect;
    in_flush = !reset && !frozen && !redirect && state == FLUSH;
    wrong_path = state == FLUSH || (state == MEM_WAIT && flush_cnt != 3'd0);
    hazard_ld = ex_mem_read && ex_rd != 5'd0 &&
                ((id_uses_rs1 && id_rs1 == ex_rd) || (id_uses_rs2 && id_rs2 == ex_rd));
    load_use = !reset && !frozen && !redirect && !wrong_path && hazard_ld;
    stall_if = frozen || load_use;
    stall_id = frozen || load_use;
    stall_ex = frozen;
    stall_mem = frozen;
    flush_if_id = redirect || in_flush;
    bubble_id_ex = redirect || load_use;
  end
  // operand forwarding: MEM result beats WB result, x0 never forwarded
  always_comb begin
    forward_a = (mem_reg_write && mem_rd != 5'd0 && mem_rd == ex_rs1) ? 2'b01 :
                (wb_reg_write && wb_rd != 5'd0 && wb_rd == ex_rs1) ? 2'b10 : 2'b00;
    forward_b = (mem_reg_write && mem_rd != 5'd0 && mem_rd == ex_rs2) ? 2'b01 :
                (wb_reg_write && wb_rd != 5'd0 && wb_rd == ex_rs2) ? 2'b10 : 2'b00;
  end
  // sequencing state: memory wait tracking, flush window countdown, sticky timeout
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RUN;
      flush_cnt <= 3'd0;
      wait_cnt <= 8'd0;
      mem_timeout <= 1'b0;
    end else if (frozen) begin
      state <= MEM_WAIT;
      wait_cnt <= (wait_cnt == WMAX) ? wait_cnt : wait_cnt + 8'd1;
      if (wait_cnt >= WMAX - 8'd1) mem_timeout <= 1'b1;
    end else begin
      wait_cnt <= 8'd0;
      if (redirect) begin
        flush_cnt <= PEN;
        state <= (PEN != 3'd0) ? FLUSH : RUN;
      end else if (state == FLUSH) begin
        flush_cnt <= flush_cnt - 3'd1;
        state <= (flush_cnt == 3'd1) ? RUN : FLUSH;
      end else begin
        state <= (flush_cnt != 3'd0) ? FLUSH : RUN;
      end
    end
  end
`ifdef HAZARD_PERF_COUNTERS_EN
  // event counters, one increment per cycle the condition drives outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_load_use_stalls <= 32'd0;
      perf_flush_cycles <= 32'd0;
      perf_mem_wait_cycles <= 32'd0;
    end else begin
      perf_load_use_stalls <= perf_load_use_stalls + 32'(load_use);
      perf_flush_cycles <= perf_flush_cycles + 32'(flush_if_id);
      perf_mem_wait_cycles <= perf_mem_wait_cycles + 32'(frozen);
    end
  end
`endif
endmodule

// File: tb/tb_hazard_control_unit.sv
// tb_hazard_control_unit: directed checks of stalls, flushes, forwarding and memory timeout
module tb_hazard_control_unit;
  logic clk = 1'b0, reset;
  logic [4:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
  logic id_uses_rs1, id_uses_rs2, ex_mem_read, ex_redirect, mem_reg_write, mem_req, mem_ready, wb_reg_write;
  logic stall_if, stall_id, stall_ex, stall_mem, flush_if_id, bubble_id_ex, mem_timeout;
  logic [1:0] forward_a, forward_b;
`ifdef HAZARD_PERF_COUNTERS_EN
  logic [31:0] perf_load_use_stalls, perf_flush_cycles, perf_mem_wait_cycles;
`endif
  int n_checks = 0, n_fail = 0;
  hazard_control_unit dut (
    .clk(clk), .reset(reset), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1),
    .id_uses_rs2(id_uses_rs2), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
    .ex_mem_read(ex_mem_read), .ex_redirect(ex_redirect), .mem_rd(mem_rd),
    .mem_reg_write(mem_reg_write), .mem_req(mem_req), .mem_ready(mem_ready), .wb_rd(wb_rd),
    .wb_reg_write(wb_reg_write), .stall_if(stall_if), .stall_id(stall_id), .stall_ex(stall_ex),
    .stall_mem(stall_mem), .flush_if_id(flush_if_id), .bubble_id_ex(bubble_id_ex),
    .forward_a(forward_a), .forward_b(forward_b),
`ifdef HAZARD_PERF_COUNTERS_EN
    .perf_load_use_stalls(perf_load_use_stalls), .perf_flush_cycles(perf_flush_cycles),
    .perf_mem_wait_cycles(perf_mem_wait_cycles),
`endif
    .mem_timeout(mem_timeout)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic idle();
    {id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd} = '0;
    {id_uses_rs1, id_uses_rs2, ex_mem_read, ex_redirect, mem_reg_write, mem_req, wb_reg_write} = '0;
    mem_ready = 1'b0;
  endtask
  task automatic next();
    @(posedge clk);
    #1;
  endtask
  task automatic load_use_in();
    idle();
    ex_mem_read = 1'b1;
    ex_rd = 5'd5;
    id_rs1 = 5'd5;
    id_uses_rs1 = 1'b1;
  endtask
  function automatic logic [7:0] ctl();
    return {2'b00, stall_if, stall_id, stall_ex, stall_mem, flush_if_id, bubble_id_ex};
  endfunction
  initial begin
    reset = 1'b1;
    idle();
    next();
    next();
    load_use_in();
    @(negedge clk);
    check("reset_gates_outputs", ctl(), 8'h00);
    next();
    reset = 1'b0;
    idle();
    @(negedge clk);
    check("post_reset_ctl", ctl(), 8'h00);
    check("post_reset_timeout", {7'd0, mem_timeout}, 8'd0);
    check("post_reset_fwd", {4'd0, forward_a, forward_b}, 8'h00);
    next();
    load_use_in();
    @(negedge clk);
    check("load_use_stall", ctl(), 8'b0011_0001);
    next();
    idle();
    mem_rd = 5'd5;
    mem_reg_write = 1'b1;
    ex_rs1 = 5'd5;
    @(negedge clk);
    check("load_use_fwd_a", {6'd0, forward_a}, 8'd1);
    check("load_use_released", ctl(), 8'h00);
    next();
    load_use_in();
    id_uses_rs1 = 1'b0;
    @(negedge clk);
    check("unused_rs1_no_stall", ctl(), 8'h00);
    next();
    load_use_in();
    id_uses_rs1 = 1'b0;
    id_rs2 = 5'd5;
    id_uses_rs2 = 1'b1;
    @(negedge clk);
    check("rs2_load_use", ctl(), 8'b0011_0001);
    next();
    load_use_in();
    ex_rd = 5'd0;
    id_rs1 = 5'd0;
    @(negedge clk);
    check("x0_load_no_stall", ctl(), 8'h00);
    next();
    idle();
    mem_rd = 5'd3;
    wb_rd = 5'd3;
    mem_reg_write = 1'b1;
    wb_reg_write = 1'b1;
    ex_rs2 = 5'd3;
    ex_rs1 = 5'd4;
    @(negedge clk);
    check("fwd_b_mem_priority", {6'd0, forward_b}, 8'd1);
    check("fwd_a_no_match", {6'd0, forward_a}, 8'd0);
    mem_rd = 5'd0;
    wb_rd = 5'd0;
    ex_rs2 = 5'd0;
    #1;
    check("fwd_b_x0", {6'd0, forward_b}, 8'd0);
    mem_rd = 5'd3;
    wb_rd = 5'd3;
    ex_rs2 = 5'd3;
    mem_reg_write = 1'b0;
    #1;
    check("fwd_b_wb", {6'd0, forward_b}, 8'd2);
    wb_rd = 5'd4;
    ex_rs1 = 5'd4;
    mem_reg_write = 1'b1;
    #1;
    check("fwd_a_wb", {6'd0, forward_a}, 8'd2);
    next();
    load_use_in();
    ex_redirect = 1'b1;
    @(negedge clk);
    check("redirect_cycle1", ctl(), 8'b0000_0011);
    next();
    load_use_in();
    @(negedge clk);
    check("redirect_cycle2", ctl(), 8'b0000_0010);
    next();
    idle();
    @(negedge clk);
    check("redirect_done", ctl(), 8'h00);
    for (int i = 0; i < 4; i++) begin
      next();
      idle();
      mem_req = 1'b1;
      ex_redirect = (i == 1);
      @(negedge clk);
      check("mem_wait_stall", ctl(), 8'b0011_1100);
    end
    next();
    idle();
    mem_req = 1'b1;
    mem_ready = 1'b1;
    @(negedge clk);
    check("mem_wait_release", ctl(), 8'h00);
    check("mem_wait_no_timeout", {7'd0, mem_timeout}, 8'd0);
    for (int i = 0; i < 16; i++) begin
      next();
      idle();
      mem_req = 1'b1;
      @(negedge clk);
      check("timeout_not_yet", {7'd0, mem_timeout}, 8'd0);
    end
    next();
    @(negedge clk);
    check("timeout_set", {7'd0, mem_timeout}, 8'd1);
    check("timeout_still_stall", ctl(), 8'b0011_1100);
    next();
    mem_ready = 1'b1;
    @(negedge clk);
    check("timeout_sticky_ready", {7'd0, mem_timeout}, 8'd1);
    check("timeout_release", ctl(), 8'h00);
    next();
    idle();
    @(negedge clk);
    check("timeout_sticky_idle", {7'd0, mem_timeout}, 8'd1);
    next();
    ex_redirect = 1'b1;
    @(negedge clk);
    check("flush_before_reset", ctl(), 8'b0000_0011);
    next();
    idle();
    reset = 1'b1;
    @(negedge clk);
    check("reset_in_flush", ctl(), 8'h00);
    next();
    reset = 1'b0;
    load_use_in();
    @(negedge clk);
    check("after_reset_run", ctl(), 8'b0011_0001);
    check("after_reset_timeout", {7'd0, mem_timeout}, 8'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
